// File: rtl/cpu_mem_arbiter.sv
// Merges the CPU instruction and data request streams onto one shared memory port
// with a single outstanding transaction. Data has priority, bounded by a starvation counter.
module cpu_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic       owner;
  logic [3:0] starve_cnt;
  logic       in_idle;
  logic       starved;
  logic       grant_data;
  logic       grant_inst;

  // Grants are masked while resetn is low so the handshakes also read as
  // idle during reset, not just the registered outputs.
  always_comb begin
    in_idle    = (state == IDLE) && resetn;
    starved    = inst_req && (starve_cnt == LIMIT);
    grant_data = in_idle && data_req && !starved;
    grant_inst = in_idle && inst_req && !grant_data;
  end

  assign data_addr_ok = grant_data;
  assign inst_addr_ok = grant_inst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (grant_data || grant_inst) state <= REQ;
        REQ:     if (mem_addr_ok) state <= WAIT;
        WAIT:    if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner     <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_data) begin
      owner     <= 1'b1;
      mem_req   <= 1'b1;
      mem_wr    <= data_wr;
      mem_wstrb <= data_wr ? data_wstrb : 4'b0000;
      mem_addr  <= data_addr;
      mem_wdata <= data_wdata;
    end else if (grant_inst) begin
      owner     <= 1'b0;
      mem_req   <= 1'b1;
      mem_wr    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= inst_addr;
      mem_wdata <= '0;
    end else if (state == REQ && mem_addr_ok) begin
      mem_req   <= 1'b0;
    end
  end

  // Completion: one-cycle pulse to the owner; stores leave data_rdata untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      if (state == WAIT && mem_data_ok) begin
        if (owner) begin
          data_data_ok <= 1'b1;
          if (!mem_wr) data_rdata <= mem_rdata;
        end else begin
          inst_data_ok <= 1'b1;
          inst_rdata   <= mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (grant_inst) begin
      starve_cnt <= '0;
    end else if (grant_data && inst_req) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else if (in_idle && !inst_req) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_cpu_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          mem_busy = 1'b0;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    mem_busy = 0;
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  // Zero-wait memory: accept as soon as mem_req is seen, complete the next cycle.
  task automatic mem_zero_wait(input logic [31:0] rd);
    mem_data_ok = mem_busy;
    mem_rdata   = rd;
    mem_addr_ok = mem_req;
    mem_busy    = mem_req;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 0;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hffffffff;
    repeat (2) next_cycle();
    settle();
    n_checks++;
    if ({mem_req, mem_wr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {mem_req, mem_wr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    n_checks++;
    if (mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_wstrb: got %h expected 0", mem_wstrb); end
    n_checks++;
    if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_checks++;
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    n_checks++;
    if ({inst_rdata, data_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata);
    end
    apply_reset();
  endtask

  task automatic test_single_load();
    apply_reset();
    data_req = 1; data_wr = 0; data_wstrb = 4'hf; data_addr = 32'h1c000100; data_wdata = $urandom();
    settle();
    n_checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      n_fail++; $display("FAIL load_c0_addr_ok: got %b expected 10", {data_addr_ok, inst_addr_ok});
    end
    next_cycle();
    data_req = 0; mem_addr_ok = 1;
    settle();
    n_checks++;
    if ({mem_req, mem_wr, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h1c000100}) begin
      n_fail++; $display("FAIL load_c1_req: got req=%b wr=%b strb=%h addr=%h expected 1 0 0 1c000100",
                         mem_req, mem_wr, mem_wstrb, mem_addr);
    end
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hdeadbeef;
    settle();
    n_checks++;
    if ({mem_req, data_data_ok} !== 2'b00) begin
      n_fail++; $display("FAIL load_c2: got req/data_ok=%b expected 00", {mem_req, data_data_ok});
    end
    next_cycle();
    mem_data_ok = 0; mem_rdata = 32'h55aa55aa;
    settle();
    n_checks++;
    if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, 32'hdeadbeef}) begin
      n_fail++; $display("FAIL load_c3: got ok=%b rdata=%h expected 10 deadbeef",
                         {data_data_ok, inst_data_ok}, data_rdata);
    end
    next_cycle();
    settle();
    n_checks++;
    if ({data_data_ok, data_rdata} !== {1'b0, 32'hdeadbeef}) begin
      n_fail++; $display("FAIL load_c4_pulse: got ok=%b rdata=%h expected 0 deadbeef", data_data_ok, data_rdata);
    end
    next_cycle();
  endtask

  // Runs after test_single_load, so data_rdata already holds deadbeef.
  task automatic test_store();
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h1c000200; data_wdata = 32'h12345678;
    settle();
    n_checks++;
    if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL store_addr_ok: got %b expected 1", data_addr_ok); end
    next_cycle();
    data_req = 0; data_wr = 0; data_wstrb = '0; mem_addr_ok = 1;
    settle();
    n_checks++;
    if ({mem_wr, mem_wstrb, mem_wdata, mem_addr} !== {1'b1, 4'b0011, 32'h12345678, 32'h1c000200}) begin
      n_fail++; $display("FAIL store_req: got wr=%b strb=%b wdata=%h addr=%h expected 1 0011 12345678 1c000200",
                         mem_wr, mem_wstrb, mem_wdata, mem_addr);
    end
    next_cycle();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hcafef00d;
    next_cycle();
    mem_data_ok = 0;
    settle();
    n_checks++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'hdeadbeef}) begin
      n_fail++; $display("FAIL store_done: got ok=%b rdata=%h expected 1 deadbeef", data_data_ok, data_rdata);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    apply_reset();
    data_req = 1; data_addr = 32'h1c000300; inst_req = 1; inst_addr = 32'hbfc00000;
    settle();
    n_checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      n_fail++; $display("FAIL stall_grant: got %b expected 10", {data_addr_ok, inst_addr_ok});
    end
    next_cycle();
    data_req = 0;
    for (int k = 0; k < 6; k++) begin
      mem_addr_ok = (k == 5);
      settle();
      n_checks++;
      if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'h1c000300, 2'b00}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got req=%b addr=%h aok=%b%b expected 1 1c000300 00",
                           k, mem_req, mem_addr, inst_addr_ok, data_addr_ok);
      end
      next_cycle();
    end
    mem_addr_ok = 0; mem_data_ok = 1;
    settle();
    n_checks++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin
      n_fail++; $display("FAIL stall_wait: got req/iaok=%b expected 00", {mem_req, inst_addr_ok});
    end
    next_cycle();
    mem_data_ok = 0;
    settle();
    n_checks++;
    if ({data_data_ok, inst_addr_ok} !== 2'b11) begin
      n_fail++; $display("FAIL stall_done: got dok/iaok=%b expected 11", {data_data_ok, inst_addr_ok});
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    string       got;
    string       want;
    int unsigned grants = 0;
    int unsigned cnt = 0;
    apply_reset();
    inst_req = 1; inst_addr = 32'h1c001000;
    data_req = 1; data_addr = 32'h1c000400;
    for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
      mem_zero_wait($urandom());
      settle();
      n_checks++;
      if (inst_addr_ok && data_addr_ok) begin
        n_fail++; $display("FAIL starve_both_ok: got 11 expected at most one");
      end
      if (inst_addr_ok || data_addr_ok) begin
        want = (cnt == LIMIT) ? "I" : "D";
        got  = data_addr_ok ? "D" : "I";
        n_checks++;
        if (got != want) begin
          n_fail++; $display("FAIL starve_order_%0d: got %s expected %s", grants, got, want);
        end
        cnt = (want == "I") ? 0 : cnt + 1;
        grants++;
      end
      next_cycle();
    end
    n_checks++;
    if (grants != 10) begin n_fail++; $display("FAIL starve_timeout: got %0d grants expected 10", grants); end
  endtask

  task automatic test_simultaneous();
    int dcyc = -1;
    int icyc = -1;
    bit dack, iack;
    apply_reset();
    inst_req = 1; inst_addr = 32'h1c002000;
    data_req = 1; data_addr = 32'h1c000500;
    for (int cyc = 0; cyc < 30 && icyc < 0; cyc++) begin
      mem_zero_wait($urandom());
      settle();
      if (cyc == 0) begin
        n_checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
          n_fail++; $display("FAIL simul_first: got %b expected 10", {data_addr_ok, inst_addr_ok});
        end
      end
      if (data_data_ok && dcyc < 0) dcyc = cyc;
      if (inst_data_ok && icyc < 0) icyc = cyc;
      dack = data_addr_ok;
      iack = inst_addr_ok;
      next_cycle();
      if (dack) data_req = 0;
      if (iack) inst_req = 0;
    end
    n_checks++;
    if (dcyc < 0 || icyc < 0) begin
      n_fail++; $display("FAIL simul_timeout: got dcyc=%0d icyc=%0d expected both seen", dcyc, icyc);
    end
    n_checks++;
    if (icyc - dcyc != 3) begin
      n_fail++; $display("FAIL simul_gap: got %0d expected 3", icyc - dcyc);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    data_req = 1; data_addr = 32'h1c000600;
    next_cycle();
    data_req = 0; mem_addr_ok = 1;
    next_cycle();
    mem_addr_ok = 0; resetn = 0;
    settle();
    n_checks++;
    if ({mem_req, mem_addr} !== 33'h0) begin
      n_fail++; $display("FAIL rstwait_immediate: got req=%b addr=%h expected 0 0", mem_req, mem_addr);
    end
    next_cycle();
    resetn = 1; mem_data_ok = 1; mem_rdata = 32'h0badf00d;
    settle();
    n_checks++;
    if ({inst_data_ok, data_data_ok, mem_req} !== 3'b000) begin
      n_fail++; $display("FAIL rstwait_c3: got %b expected 000", {inst_data_ok, data_data_ok, mem_req});
    end
    next_cycle();
    mem_data_ok = 0;
    settle();
    n_checks++;
    if ({inst_data_ok, data_data_ok, data_rdata} !== 34'h0) begin
      n_fail++; $display("FAIL rstwait_no_pulse: got ok=%b rdata=%h expected 00 0",
                         {inst_data_ok, data_data_ok}, data_rdata);
    end
    next_cycle();
  endtask

  task automatic test_random();
    txn_t        inflight[$];
    txn_t        t;
    bit          accepted = 0;
    int unsigned m_starve = 0;
    logic [31:0] m_inst_rd = '0;
    logic [31:0] m_data_rd = '0;
    bit          exp_iok = 0;
    bit          exp_dok = 0;
    bit          eg_data, eg_inst, iack = 0, dack = 0;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++;
      if ({inst_data_ok, data_data_ok} !== {exp_iok, exp_dok}) begin
        n_fail++; $display("FAIL rand_data_ok@%0d: got %b expected %b", cyc,
                           {inst_data_ok, data_data_ok}, {exp_iok, exp_dok});
      end
      n_checks++;
      if ({inst_rdata, data_rdata} !== {m_inst_rd, m_data_rd}) begin
        n_fail++; $display("FAIL rand_rdata@%0d: got %h/%h expected %h/%h", cyc,
                           inst_rdata, data_rdata, m_inst_rd, m_data_rd);
      end
      n_checks++;
      if (mem_req !== (inflight.size() != 0 && !accepted)) begin
        n_fail++; $display("FAIL rand_mem_req@%0d: got %b expected %b", cyc, mem_req,
                           inflight.size() != 0 && !accepted);
      end
      if (inflight.size() != 0 && !accepted) begin
        t = inflight[0];
        n_checks++;
        if ({mem_addr, mem_wr, mem_wstrb} !== {t.addr, t.wr, t.wstrb} ||
            (t.owner && mem_wdata !== t.wdata)) begin
          n_fail++; $display("FAIL rand_mem_fields@%0d: got %h %b %h %h expected %h %b %h %h", cyc,
                             mem_addr, mem_wr, mem_wstrb, mem_wdata, t.addr, t.wr, t.wstrb, t.wdata);
        end
      end

      if (iack) inst_req = 0;
      if (dack) data_req = 0;
      if (!inst_req && $urandom_range(2) == 0) begin
        inst_req = 1; inst_addr = {$urandom_range(32'h3fffffff), 2'b00};
      end
      if (!data_req && $urandom_range(2) == 0) begin
        data_req = 1; data_wr = $urandom_range(1); data_wstrb = 4'($urandom());
        data_addr = $urandom(); data_wdata = $urandom();
      end
      mem_addr_ok = ($urandom_range(1) == 0);
      mem_data_ok = ($urandom_range(2) == 0);
      mem_rdata   = $urandom();

      settle();
      eg_data = 0; eg_inst = 0;
      if (inflight.size() == 0) begin
        eg_data = data_req && !(inst_req && m_starve == LIMIT);
        eg_inst = inst_req && !eg_data;
      end
      n_checks++;
      if ({data_addr_ok, inst_addr_ok} !== {eg_data, eg_inst}) begin
        n_fail++; $display("FAIL rand_grant@%0d: got %b expected %b", cyc,
                           {data_addr_ok, inst_addr_ok}, {eg_data, eg_inst});
      end

      exp_iok = 0; exp_dok = 0;
      if (inflight.size() == 0) begin
        if (eg_data) inflight.push_back({1'b1, data_addr, data_wr, data_wr ? data_wstrb : 4'h0, data_wdata});
        if (eg_inst) inflight.push_back({1'b0, inst_addr, 1'b0, 4'h0, 32'h0});
        if (eg_inst) m_starve = 0;
        else if (eg_data && inst_req) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else if (!inst_req) m_starve = 0;
      end else if (!accepted) begin
        if (mem_addr_ok) accepted = 1;
      end else if (mem_data_ok) begin
        t = inflight.pop_front();
        accepted = 0;
        if (t.owner) begin
          exp_dok = 1;
          if (!t.wr) m_data_rd = mem_rdata;
        end else begin
          exp_iok = 1;
          m_inst_rd = mem_rdata;
        end
      end
      iack = eg_inst;
      dack = eg_data;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_single_load();
    test_store();
    test_stall();
    test_starvation();
    test_simultaneous();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Sits directly downstream of the CPU top's instruction and data memory ports. Merges the two request streams onto one shared memory port with a single outstanding transaction. Gives data accesses priority, with a starvation counter so instruction fetch always makes progress. Each accepted request is registered, issued with a req/addr_ok handshake, and its completion is returned as a one-cycle `*_data_ok` pulse to the stream that issued it.

## Interface
- STARVE_LIMIT, 4, number of consecutive data grants while `inst_req` is pending, after which the next grant goes to instruction; legal range 1..15
- clk  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- inst_req  in  1  instruction fetch request, held until `inst_addr_ok`
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch accepted this cycle
- inst_data_ok  out  1  one-cycle pulse, `inst_rdata` valid
- inst_rdata  out  32  fetched word
- data_req  in  1  data request, held until `data_addr_ok`
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  byte enables for a store
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  one-cycle pulse marking load data valid or store done
- data_rdata  out  32  load data
- mem_req  out  1  shared port request, held until `mem_addr_ok`
- mem_wr  out  1  registered write flag
- mem_wstrb  out  4  registered strobe; forced to 4'b0000 for loads
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered store data
- mem_addr_ok  in  1  memory accepted the request
- mem_data_ok  in  1  memory completed; `mem_rdata` valid
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- IDLE, grant logic (combinational):
  - Grant data if `data_req` and not (`inst_req` and starve_cnt == STARVE_LIMIT).
  - Otherwise grant inst if `inst_req`.
  - The granted stream sees its `*_addr_ok`=1 this cycle. At most one `*_addr_ok` is high per cycle.
- On a grant, the following are registered: owner bit (0 inst, 1 data), addr, wr, wstrb, wdata. The FSM moves to REQ.
  - An inst grant registers wr=0 and wstrb=0.
- starve_cnt (4 bit):
  - Increments on a data grant while `inst_req`=1, saturating at STARVE_LIMIT.
  - Clears on any inst grant.
  - Clears in IDLE when `inst_req`=0.
- REQ: `mem_req`=1. Move to WAIT on `mem_addr_ok`.
- WAIT: move to IDLE on `mem_data_ok`.
  - Register `mem_rdata` into the owner's rdata register.
  - Pulse the owner's `*_data_ok` in the next cycle.
- `mem_data_ok` is ignored outside WAIT. `mem_addr_ok` is ignored outside REQ.
- Each rdata register holds its last value until the next completion for that stream.
- Stores also pulse `data_data_ok`. `data_rdata` is not updated on a store.
- Reset mid-transaction: the FSM returns to IDLE, `mem_req` drops, and any pending response is discarded without a `data_ok`.

## Timing
- Reset values:
  - `mem_req`, `mem_wr`, `*_data_ok`, `*_addr_ok`: 0.
  - `mem_addr`, `mem_wdata`, `*_rdata`: 32'h0.
  - `mem_wstrb`: 0.
  - starve_cnt: 0.
- `*_addr_ok` is combinational from state and req inputs. All other outputs are registered.
- Minimum transaction:
  - c0: IDLE, addr_ok.
  - c1: `mem_req`=1, `mem_addr_ok`=1.
  - c2: WAIT, `mem_data_ok`=1.
  - c3: `*_data_ok`=1, back in IDLE, a new grant is possible in c3.
- Throughput: one transaction per 3 cycles maximum.
- `mem_*` request fields are stable from entry to REQ until `mem_addr_ok`.
- Simultaneous `inst_req` and `data_req` with starve_cnt < STARVE_LIMIT: data wins.

## Test plan
- Single load: `data_req`, addr 0x1c000100, `mem_addr_ok` in c1, `mem_data_ok` in c2 with rdata 0xdeadbeef. Required: `data_addr_ok` in c0, `mem_req` in c1 only, `data_data_ok`=1 and `data_rdata`=0xdeadbeef in c3.
- Store: wr=1, wstrb=4'b0011, wdata 0x12345678. Required: `mem_wr`=1 and `mem_wstrb`=4'b0011 in REQ; `data_data_ok` pulse; `data_rdata` unchanged.
- Memory stall: `mem_addr_ok` delayed 5 cycles. Required: `mem_req` and `mem_addr` stable for 6 cycles; no second `*_addr_ok` during this time.
- Starvation with STARVE_LIMIT=4 and both reqs held high continuously. Required grant order: D, D, D, D, I, D, …
- Simultaneous first requests: data granted first, inst granted next in IDLE. `inst_data_ok` follows `data_data_ok` by 3 cycles given zero-wait memory.
- Reset in WAIT: deassert `resetn` for 1 cycle, then `mem_data_ok`. Required: all outputs return to reset values immediately and no `*_data_ok` pulse occurs.
